sd_cmd_engine: RTL and testbench
================================

SD_CMD_ENGINE -- requirements
Module: sd_cmd_engine

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64: max cycles in WAIT_RESP before timeout (range 2..255).
REQ-002 SHALL have parameter MAX_RETRY, default 3: re-sends allowed after CRC/timeout failure (0 = none).
REQ-003 SHALL have parameter NCC, default 8: minimum idle cycles (line high) after response end or no-response command end.
REQ-004 SHALL have ports, one clock; reset is asynchronous and active-high:
- iclk  in  1  SD clock
- irst  in  1  async active-high reset
- icmd_sd  in  1  sampled CMD line
- ocmd_sd  out  1  CMD line drive value
- ocmd_oe  out  1  CMD output enable
- istart  in  1  start request, rising edge triggers
- icmd_index  in  6  command index
- icmd_arg  in  32  command argument
- iresp_type  in  2  00 none, 01 short+CRC+index check, 10 long (R2), 11 short no check (R3)
- oresp  out  128  received response payload
- oresp_index  out  6  received index field (short)
- obusy  out  1  transaction in progress
- odone  out  1  one-cycle completion pulse
- otimeout  out  1  final attempt timed out
- ocrc_err  out  1  final attempt CRC/index/end-bit error
- oretries  out  2  retries used by last transaction (saturates at 3)

Function
REQ-005 SHALL detect start when istart=1 and its previous-cycle sample=0 (cycle 0), only in IDLE; ignored otherwise.
REQ-006 SHALL latch icmd_index, icmd_arg, iresp_type at cycle 0; later input changes have no effect until next start.
REQ-007 SHALL clear otimeout, ocrc_err, oretries at cycle 0.
REQ-008 SHALL have states IDLE, SEND, WAIT_RESP, RCV, GAP.
REQ-009 SEND: cycles 1..48 drive frame MSB first: 0, 1, index[5:0], arg[31:0], CRC7[6:0], 1; ocmd_oe=1 exactly those 48 cycles.
REQ-010 CRC7 SHALL use polynomial x^7+x^3+1, register cleared per frame, computed over the first 40 bits.
REQ-011 Outside SEND, ocmd_sd SHALL be 1 and ocmd_oe 0.
REQ-012 After SEND: type 00 -> GAP; otherwise -> WAIT_RESP.
REQ-013 WAIT_RESP: first sampled icmd_sd=0 is the response start bit -> RCV; if none within TIMEOUT cycles -> timeout failure.
REQ-014 RCV SHALL capture 48 bits total (types 01/11) or 136 bits (type 10), start bit included.
REQ-015 Type 01: oresp[31:0]=bits 39:8, oresp[127:32]=0, oresp_index=bits 45:40; fail if CRC7 over bits 47:8 differs from bits 7:1, index differs from latched index, or end bit=0.
REQ-016 Type 10: oresp[127:1]=bits 127:1, oresp[0]=0, oresp_index=6'h3F; fail if CRC7 over bits 127:8 differs from bits 7:1 or end bit=0.
REQ-017 Type 11: capture as type 01; no CRC/index check; end bit=0 still fails.
REQ-018 After RCV or failure SHALL enter GAP for NCC cycles.
REQ-019 On GAP exit: on failure with retries < MAX_RETRY, increment retry count and re-enter SEND with the same latched frame; else -> IDLE.
REQ-020 On IDLE entry: odone=1 for one cycle; otimeout/ocrc_err reflect only the final attempt and hold until next start.
REQ-021 obusy SHALL be 1 from cycle 0 through the last GAP cycle.
REQ-022 Counters SHALL be 8 bits; retry counter SHALL not wrap.

Reset
REQ-023 irst=1 SHALL immediately force IDLE, ocmd_sd=1, ocmd_oe=0, obusy=0, odone=0, all flags/counters/oresp/oresp_index=0, edge-detect register=0, including mid-transaction.
REQ-024 istart held high through reset release SHALL trigger a start on the first post-reset cycle.

Verification
- CMD0, arg 0, type 00 -> ocmd_sd bytes 40 00 00 00 00 95, oe 48 cycles, odone 8 cycles after end bit, no flags.
- CMD8, arg 0x1AA, type 01, model replies 3 cycles later with valid R7 -> frame ends ...01 AA 87; oresp=0x1AA, oresp_index=8, no flags.
- CMD2, type 10, valid 136-bit R2 -> oresp[127:1] matches model CID; ocrc_err=0.
- Type 01, no reply, MAX_RETRY=3 -> 4 frames each separated by TIMEOUT+NCC idle; otimeout=1, oretries=3.
- Type 01 reply with one flipped CRC bit then valid reply on retry -> ocrc_err=0, oretries=1.
- irst pulse at SEND bit 20 -> ocmd_sd=1, oe=0 same cycle; istart pulse after release yields clean CMD frame.

Source files
------------

// File: rtl/sd_cmd_engine.sv
// SD-bus command engine: serialises a 48-bit CMD frame with CRC7, collects the
// card response, validates it and retries failed attempts up to MAX_RETRY times.
module sd_cmd_engine #(
    parameter int TIMEOUT   = 64,
    parameter int MAX_RETRY = 3,
    parameter int NCC       = 8
) (
    input  logic         iclk,
    input  logic         irst,
    input  logic         icmd_sd,
    output logic         ocmd_sd,
    output logic         ocmd_oe,
    input  logic         istart,
    input  logic [5:0]   icmd_index,
    input  logic [31:0]  icmd_arg,
    input  logic [1:0]   iresp_type,
    output logic [127:0] oresp,
    output logic [5:0]   oresp_index,
    output logic         obusy,
    output logic         odone,
    output logic         otimeout,
    output logic         ocrc_err,
    output logic [1:0]   oretries
);

    localparam logic [7:0] TO_LAST   = 8'(TIMEOUT - 1);
    localparam logic [7:0] GAP_LAST  = 8'(NCC - 1);
    localparam logic [7:0] RETRY_MAX = 8'(MAX_RETRY);

    typedef enum logic [2:0] {IDLE, SEND, WAIT_RESP, RCV, GAP} state_t;

    state_t         state, state_nx;
    logic           start_q;
    logic [5:0]     idx_q;
    logic [31:0]    arg_q;
    logic [1:0]     typ_q;
    logic [7:0]     cnt;
    logic [7:0]     retry;
    logic [135:0]   sr;
    logic           att_to, att_crc;

    // Leading zeros leave a cleared CRC register untouched, so short fields are
    // zero-extended into the same 120-bit engine.
    function automatic logic [6:0] crc7(input logic [119:0] d);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int i = 119; i >= 0; i--) begin
            fb = d[i] ^ c[6];
            c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        return c;
    endfunction

    logic [39:0]  tx_body;
    logic [47:0]  tx_frame;
    logic [135:0] sr_nx;
    logic         start_det, send_last, rcv_last, gap_last, retry_go, rx_fail;
    logic         short_crc_bad, long_crc_bad, idx_bad, end_bad;

    assign tx_body   = {2'b01, idx_q, arg_q};
    assign tx_frame  = {tx_body, crc7({80'b0, tx_body}), 1'b1};
    assign sr_nx     = {sr[134:0], icmd_sd};

    assign start_det = (state == IDLE) && istart && !start_q && !irst;
    assign send_last = (cnt == 8'd47);
    assign rcv_last  = (typ_q == 2'b10) ? (cnt == 8'd135) : (cnt == 8'd47);
    assign gap_last  = (cnt == GAP_LAST);
    assign retry_go  = (att_to || att_crc) && (retry < RETRY_MAX);

    assign short_crc_bad = crc7({80'b0, sr_nx[47:8]}) != sr_nx[7:1];
    assign long_crc_bad  = crc7(sr_nx[127:8]) != sr_nx[7:1];
    assign idx_bad       = sr_nx[45:40] != idx_q;
    assign end_bad       = !sr_nx[0];

    always_comb begin
        rx_fail = end_bad;
        case (typ_q)
            2'b01:   rx_fail = short_crc_bad || idx_bad || end_bad;
            2'b10:   rx_fail = long_crc_bad || end_bad;
            default: rx_fail = end_bad;
        endcase
    end

    assign ocmd_oe  = (state == SEND);
    assign ocmd_sd  = (state == SEND) ? tx_frame[6'd47 - cnt[5:0]] : 1'b1;
    assign obusy    = (state != IDLE) || start_det;
    assign oretries = (retry > 8'd3) ? 2'd3 : retry[1:0];

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (start_det) state_nx = SEND;
            SEND:      if (send_last) state_nx = (typ_q == 2'b00) ? GAP : WAIT_RESP;
            WAIT_RESP: begin
                if (!icmd_sd)            state_nx = RCV;
                else if (cnt == TO_LAST) state_nx = GAP;
            end
            RCV:       if (rcv_last) state_nx = GAP;
            GAP:       if (gap_last) state_nx = retry_go ? SEND : IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            state       <= IDLE;
            start_q     <= 1'b0;
            idx_q       <= '0;
            arg_q       <= '0;
            typ_q       <= '0;
            cnt         <= '0;
            retry       <= '0;
            sr          <= '0;
            att_to      <= 1'b0;
            att_crc     <= 1'b0;
            oresp       <= '0;
            oresp_index <= '0;
            odone       <= 1'b0;
            otimeout    <= 1'b0;
            ocrc_err    <= 1'b0;
        end else begin
            state   <= state_nx;
            start_q <= istart;
            odone   <= 1'b0;
            case (state)
                IDLE: if (start_det) begin
                    idx_q    <= icmd_index;
                    arg_q    <= icmd_arg;
                    typ_q    <= iresp_type;
                    cnt      <= '0;
                    retry    <= '0;
                    att_to   <= 1'b0;
                    att_crc  <= 1'b0;
                    otimeout <= 1'b0;
                    ocrc_err <= 1'b0;
                end
                SEND: cnt <= send_last ? 8'd0 : cnt + 8'd1;
                WAIT_RESP: begin
                    if (!icmd_sd) begin
                        sr  <= sr_nx;
                        cnt <= 8'd1;  // start bit already taken
                    end else if (cnt == TO_LAST) begin
                        att_to <= 1'b1;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                RCV: begin
                    sr <= sr_nx;
                    if (rcv_last) begin
                        cnt     <= '0;
                        att_crc <= rx_fail;
                        if (typ_q == 2'b10) begin
                            oresp       <= {sr_nx[127:1], 1'b0};
                            oresp_index <= 6'h3F;
                        end else begin
                            oresp       <= {96'b0, sr_nx[39:8]};
                            oresp_index <= sr_nx[45:40];
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                GAP: begin
                    if (gap_last) begin
                        cnt <= '0;
                        if (retry_go) begin
                            retry   <= retry + 8'd1;
                            att_to  <= 1'b0;
                            att_crc <= 1'b0;
                        end else begin
                            odone    <= 1'b1;
                            otimeout <= att_to;
                            ocrc_err <= att_crc;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_cmd_engine.sv
// Scoreboard bench for sd_cmd_engine: directed commands, a card responder model,
// and a monitor that checks every frame and every completed transaction.
module tb_sd_cmd_engine;

    localparam int TO = 64;
    localparam int NC = 8;
    localparam int MR = 3;

    logic         iclk = 1'b0;
    logic         irst;
    logic         icmd_sd;
    logic         ocmd_sd, ocmd_oe;
    logic         istart;
    logic [5:0]   icmd_index;
    logic [31:0]  icmd_arg;
    logic [1:0]   iresp_type;
    logic [127:0] oresp;
    logic [5:0]   oresp_index;
    logic         obusy, odone, otimeout, ocrc_err;
    logic [1:0]   oretries;

    sd_cmd_engine #(.TIMEOUT(TO), .MAX_RETRY(MR), .NCC(NC)) dut (
        .iclk(iclk), .irst(irst), .icmd_sd(icmd_sd), .ocmd_sd(ocmd_sd), .ocmd_oe(ocmd_oe),
        .istart(istart), .icmd_index(icmd_index), .icmd_arg(icmd_arg), .iresp_type(iresp_type),
        .oresp(oresp), .oresp_index(oresp_index), .obusy(obusy), .odone(odone),
        .otimeout(otimeout), .ocrc_err(ocrc_err), .oretries(oretries)
    );

    always #5 iclk = ~iclk;

    typedef struct {
        logic [47:0]  frame;
        int           nfr;
        logic [127:0] resp;
        logic [5:0]   ridx;
        logic         to;
        logic         crc;
        logic [1:0]   rtr;
        int           gap;   // idle cycles between frames, -1 = unchecked
        int           tail;  // idle cycles from last end bit to odone, -1 = unchecked
    } exp_t;

    typedef struct {
        int           dly;
        logic [135:0] bits;
        int           len;
    } rsp_t;

    exp_t exp_q[$];
    rsp_t rsp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    function automatic logic [6:0] tcrc(input logic [119:0] d, input int n);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int i = n - 1; i >= 0; i--) begin
            fb   = d[i] ^ c[6];
            c[6] = c[5]; c[5] = c[4]; c[4] = c[3];
            c[3] = c[2] ^ fb;
            c[2] = c[1]; c[1] = c[0]; c[0] = fb;
        end
        return c;
    endfunction

    function automatic logic [135:0] mk_short(input logic [5:0] idx, input logic [31:0] arg,
                                              input logic [6:0] flip);
        logic [39:0] m;
        m = {2'b00, idx, arg};
        return {88'b0, m, tcrc({80'b0, m}, 40) ^ flip, 1'b1};
    endfunction

    task automatic expect_txn(input logic [47:0] fr, input int nfr, input logic [127:0] resp,
                              input logic [5:0] ridx, input logic to, input logic crc,
                              input logic [1:0] rtr, input int gap, input int tail);
        exp_t e;
        e.frame = fr; e.nfr = nfr; e.resp = resp; e.ridx = ridx; e.to = to;
        e.crc = crc; e.rtr = rtr; e.gap = gap; e.tail = tail;
        exp_q.push_back(e);
    endtask

    task automatic add_rsp(input int dly, input logic [135:0] bits, input int len);
        rsp_t r;
        r.dly = dly; r.bits = bits; r.len = len;
        rsp_q.push_back(r);
    endtask

    task automatic start_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] t);
        @(negedge iclk);
        icmd_index = idx; icmd_arg = arg; iresp_type = t; istart = 1'b1;
        @(negedge iclk);
        istart = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 3000) begin
            @(negedge iclk);
            k++;
        end
        if (exp_q.size() != 0) begin
            n_vec++; n_err++;
            $display("FAIL %s: transaction did not complete within 3000 cycles", nm);
            exp_q.delete();
        end
        repeat (3) @(negedge iclk);
    endtask

    // Card model: after each command frame, answer with the next queued response.
    initial begin
        logic prev_oe;
        rsp_t r;
        icmd_sd = 1'b1;
        prev_oe = 1'b0;
        forever begin
            @(negedge iclk);
            if (!irst && prev_oe && !ocmd_oe && rsp_q.size() != 0) begin
                r = rsp_q.pop_front();
                repeat (r.dly) @(negedge iclk);
                for (int i = r.len - 1; i >= 0; i--) begin
                    icmd_sd = r.bits[i];
                    @(negedge iclk);
                end
                icmd_sd = 1'b1;
            end
            prev_oe = ocmd_oe;
        end
    end

    // Monitor: checks each frame as it ends and each transaction on odone.
    initial begin
        logic        m_prev_oe;
        logic [47:0] fr_sh;
        int          nfr, oe_cnt, idle_cnt;
        exp_t        e;
        m_prev_oe = 1'b0; fr_sh = '0; nfr = 0; oe_cnt = 0; idle_cnt = 0;
        forever begin
            @(negedge iclk);
            if (irst) begin
                m_prev_oe = 1'b0; fr_sh = '0; nfr = 0; oe_cnt = 0; idle_cnt = 0;
            end else begin
                if (odone) begin
                    if (exp_q.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL done: odone with no transaction outstanding");
                    end else begin
                        e = exp_q.pop_front();
                        chk("frames", 128'(nfr), 128'(e.nfr));
                        chk("oe_cycles", 128'(oe_cnt), 128'(48 * e.nfr));
                        chk("oresp", oresp, e.resp);
                        chk("oresp_index", 128'(oresp_index), 128'(e.ridx));
                        chk("otimeout", 128'(otimeout), 128'(e.to));
                        chk("ocrc_err", 128'(ocrc_err), 128'(e.crc));
                        chk("oretries", 128'(oretries), 128'(e.rtr));
                        chk("obusy_at_done", 128'(obusy), 128'(0));
                        if (e.tail >= 0) chk("done_delay", 128'(idle_cnt), 128'(e.tail));
                    end
                    nfr = 0; oe_cnt = 0;
                end
                if (ocmd_oe) begin
                    if (!m_prev_oe) begin
                        if (nfr > 0 && exp_q.size() != 0 && exp_q[0].gap >= 0)
                            chk("frame_gap", 128'(idle_cnt), 128'(exp_q[0].gap));
                        nfr++;
                    end
                    fr_sh = {fr_sh[46:0], ocmd_sd};
                    oe_cnt++;
                    idle_cnt = 0;
                end else begin
                    if (m_prev_oe) begin
                        if (exp_q.size() != 0) chk("frame", 128'(fr_sh), 128'(exp_q[0].frame));
                        else begin
                            n_vec++; n_err++;
                            $display("FAIL frame: unexpected frame %0h", fr_sh);
                        end
                    end
                    idle_cnt++;
                end
                m_prev_oe = ocmd_oe;
            end
        end
    end

    initial begin
        logic [119:0] cid;
        logic [6:0]   cid_crc;
        logic [127:0] r2_exp;
        int           k;
        irst = 1'b1; istart = 1'b0; icmd_index = '0; icmd_arg = '0; iresp_type = '0;
        cid     = 120'h035344534436344780123456780166;
        cid_crc = tcrc(cid, 120);
        r2_exp  = {cid, cid_crc, 1'b0};

        repeat (3) @(negedge iclk);
        chk("rst_cmd_sd", 128'(ocmd_sd), 128'(1));
        chk("rst_oe", 128'(ocmd_oe), 128'(0));
        chk("rst_busy", 128'(obusy), 128'(0));
        chk("rst_done", 128'(odone), 128'(0));
        chk("rst_flags", 128'({otimeout, ocrc_err, oretries}), 128'(0));
        chk("rst_resp", oresp, 128'(0));
        irst = 1'b0;
        repeat (2) @(negedge iclk);

        // CMD0, no response
        expect_txn(48'h400000000095, 1, 128'(0), 6'd0, 0, 0, 2'd0, -1, NC);
        start_cmd(6'd0, 32'h0, 2'b00);
        wait_idle("cmd0");

        // CMD8 with R7; a second start mid-frame must be ignored
        add_rsp(3, mk_short(6'd8, 32'h1AA, 7'h00), 48);
        expect_txn(48'h48000001AA87, 1, 128'h1AA, 6'd8, 0, 0, 2'd0, -1, -1);
        start_cmd(6'd8, 32'h1AA, 2'b01);
        repeat (5) @(negedge iclk);
        icmd_index = 6'd2; icmd_arg = 32'hDEAD_BEEF; iresp_type = 2'b00; istart = 1'b1;
        @(negedge iclk);
        istart = 1'b0;
        wait_idle("cmd8_r7");

        // CMD2 with 136-bit R2
        add_rsp(5, {2'b00, 6'h3F, cid, cid_crc, 1'b1}, 136);
        expect_txn(48'h42000000004D, 1, r2_exp, 6'h3F, 0, 0, 2'd0, -1, -1);
        start_cmd(6'd2, 32'h0, 2'b10);
        wait_idle("cmd2_r2");

        // No reply at all: every attempt times out
        expect_txn(48'h48000001AA87, 4, r2_exp, 6'h3F, 1, 0, 2'd3, TO + NC, -1);
        start_cmd(6'd8, 32'h1AA, 2'b01);
        wait_idle("timeout");

        // Corrupted CRC first, good reply on the retry
        add_rsp(3, mk_short(6'd8, 32'h1AA, 7'h01), 48);
        add_rsp(3, mk_short(6'd8, 32'h1AA, 7'h00), 48);
        expect_txn(48'h48000001AA87, 2, 128'h1AA, 6'd8, 0, 0, 2'd1, -1, -1);
        start_cmd(6'd8, 32'h1AA, 2'b01);
        wait_idle("crc_retry");

        // R3 style: index/CRC fields are all ones and must not be checked
        add_rsp(2, {88'b0, 2'b00, 6'h3F, 32'h80FF8000, 7'h7F, 1'b1}, 48);
        expect_txn(48'h770000000065, 1, 128'h80FF8000, 6'h3F, 0, 0, 2'd0, -1, -1);
        start_cmd(6'd55, 32'h0, 2'b11);
        wait_idle("r3_ok");

        // R3 with a bad end bit on every attempt
        for (int i = 0; i < 4; i++) add_rsp(2, {88'b0, 2'b00, 6'h3F, 32'h00FF8000, 7'h7F, 1'b0}, 48);
        expect_txn(48'h770000000065, 4, 128'h00FF8000, 6'h3F, 0, 1, 2'd3, -1, -1);
        start_cmd(6'd55, 32'h0, 2'b11);
        wait_idle("r3_endbit");

        // Reset at bit 20 of a frame
        start_cmd(6'd8, 32'h1AA, 2'b01);
        k = 0;
        while (!ocmd_oe && k < 50) begin @(negedge iclk); k++; end
        repeat (20) @(negedge iclk);
        #2 irst = 1'b1;
        #1;
        chk("midrst_cmd_sd", 128'(ocmd_sd), 128'(1));
        chk("midrst_oe", 128'(ocmd_oe), 128'(0));
        chk("midrst_busy", 128'(obusy), 128'(0));
        chk("midrst_resp", oresp, 128'(0));
        chk("midrst_idx", 128'(oresp_index), 128'(0));
        repeat (2) @(negedge iclk);
        irst = 1'b0;
        repeat (2) @(negedge iclk);
        expect_txn(48'h400000000095, 1, 128'(0), 6'd0, 0, 0, 2'd0, -1, NC);
        start_cmd(6'd0, 32'h0, 2'b00);
        wait_idle("post_rst_cmd0");

        // istart held high across reset release starts on the first cycle
        @(negedge iclk);
        irst = 1'b1;
        icmd_index = 6'd2; icmd_arg = 32'h0; iresp_type = 2'b00; istart = 1'b1;
        repeat (2) @(negedge iclk);
        chk("held_start_busy_in_rst", 128'(obusy), 128'(0));
        expect_txn(48'h42000000004D, 1, 128'(0), 6'd0, 0, 0, 2'd0, -1, NC);
        irst = 1'b0;
        #1;
        chk("held_start_busy", 128'(obusy), 128'(1));
        @(negedge iclk);
        istart = 1'b0;
        wait_idle("held_start");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
